// File: rtl/uart_frame_reader.sv
`default_nettype none
// ============================================================================
// Module  : uart_frame_reader
// Brief   : Paced reader for a UART receive FIFO. Assembles SYNC/LEN/payload/
//           checksum frames into a local buffer and streams checksum-good
//           payloads downstream over a valid/ready port.
// Revision: 1.0 - initial release
// ============================================================================
module uart_frame_reader #(
  parameter logic [7:0] SYNC    = 8'h7E,
  parameter int         MAX_LEN = 16,
  parameter int         RD_GAP  = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx_data_present,
  input  logic [7:0] rx_data,
  output logic       read_from_uart,
  output logic       out_valid,
  output logic [7:0] out_data,
  output logic       out_last,
  input  logic       out_ready,
  output logic       frame_error,
  output logic [7:0] frame_count,
  output logic       busy
);

  localparam int             IW        = $clog2(MAX_LEN + 1);
  localparam int             GW        = $clog2(RD_GAP + 1);
  localparam int             DEPTH     = 1 << IW;
  localparam logic [GW-1:0]  GAP_LOAD  = GW'(RD_GAP);
  localparam logic [7:0]     MAX_LEN_B = 8'(MAX_LEN);
  localparam logic [IW-1:0]  ONE_IDX   = IW'(1);

  typedef enum logic [2:0] {
    S_HUNT    = 3'd0,
    S_LEN     = 3'd1,
    S_PAYLOAD = 3'd2,
    S_CHECK   = 3'd3,
    S_DRAIN   = 3'd4
  } state_t;

  state_t        state, state_nxt;
  logic [GW-1:0] gap, gap_nxt;
  logic [IW-1:0] len, len_nxt;
  logic [IW-1:0] idx, idx_nxt, idx_inc;
  logic [7:0]    sum, sum_nxt, sum_add;
  logic [7:0]    mem [DEPTH];

  logic          take;
  logic          wr_en;
  logic          out_valid_nxt;
  logic [7:0]    out_data_nxt;
  logic          out_last_nxt;
  logic          frame_error_nxt;
  logic [7:0]    frame_count_nxt;
  logic          busy_nxt;

  // A byte is taken only once the cooldown has expired, and never while a
  // frame is being drained so the UART FIFO absorbs downstream backpressure.
  assign take    = rx_data_present && (gap == '0) && (state != S_DRAIN);
  assign idx_inc = idx + 1'b1;
  assign sum_add = sum + rx_data;
  assign wr_en   = take && (state == S_PAYLOAD);

  // Next-state, datapath and registered-output computation.
  always_comb begin
    state_nxt       = state;
    len_nxt         = len;
    idx_nxt         = idx;
    sum_nxt         = sum;
    out_valid_nxt   = out_valid;
    out_data_nxt    = out_data;
    out_last_nxt    = out_last;
    frame_error_nxt = 1'b0;
    frame_count_nxt = frame_count;

    // Cooldown runs independently of the frame state and survives errors.
    if (take) begin
      gap_nxt = GAP_LOAD;
    end else if (gap != '0) begin
      gap_nxt = gap - 1'b1;
    end else begin
      gap_nxt = gap;
    end

    case (state)
      S_HUNT: begin
        if (take && (rx_data == SYNC)) begin
          state_nxt = S_LEN;
        end
      end
      S_LEN: begin
        if (take) begin
          if ((rx_data == 8'h00) || (rx_data > MAX_LEN_B)) begin
            frame_error_nxt = 1'b1;
            state_nxt       = S_HUNT;
          end else begin
            len_nxt   = rx_data[IW-1:0];
            sum_nxt   = rx_data;
            idx_nxt   = '0;
            state_nxt = S_PAYLOAD;
          end
        end
      end
      S_PAYLOAD: begin
        if (take) begin
          sum_nxt = sum_add;
          idx_nxt = idx_inc;
          if (idx_inc == len) begin
            state_nxt = S_CHECK;
          end
        end
      end
      S_CHECK: begin
        if (take) begin
          if (sum_add == 8'h00) begin
            state_nxt     = S_DRAIN;
            idx_nxt       = '0;
            out_valid_nxt = 1'b1;
            out_data_nxt  = mem[0];
            out_last_nxt  = (len == ONE_IDX);
          end else begin
            frame_error_nxt = 1'b1;
            state_nxt       = S_HUNT;
          end
        end
      end
      S_DRAIN: begin
        if (out_valid && out_ready) begin
          if (idx_inc == len) begin
            state_nxt       = S_HUNT;
            out_valid_nxt   = 1'b0;
            out_last_nxt    = 1'b0;
            frame_count_nxt = frame_count + 8'd1;
          end else begin
            idx_nxt      = idx_inc;
            out_data_nxt = mem[idx_inc];
            out_last_nxt = ((idx_inc + 1'b1) == len);
          end
        end
      end
      default: begin
        state_nxt = S_HUNT;
      end
    endcase

    busy_nxt = (state_nxt != S_HUNT);
  end

  // State register and registered outputs; reset discards any partial frame.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state          <= S_HUNT;
      gap            <= '0;
      len            <= '0;
      idx            <= '0;
      sum            <= '0;
      read_from_uart <= 1'b0;
      out_valid      <= 1'b0;
      out_data       <= '0;
      out_last       <= 1'b0;
      frame_error    <= 1'b0;
      frame_count    <= '0;
      busy           <= 1'b0;
    end else begin
      state          <= state_nxt;
      gap            <= gap_nxt;
      len            <= len_nxt;
      idx            <= idx_nxt;
      sum            <= sum_nxt;
      read_from_uart <= take;
      out_valid      <= out_valid_nxt;
      out_data       <= out_data_nxt;
      out_last       <= out_last_nxt;
      frame_error    <= frame_error_nxt;
      frame_count    <= frame_count_nxt;
      busy           <= busy_nxt;
    end
  end

  // Payload buffer; contents are only meaningful between LEN and DRAIN.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[idx] <= rx_data;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_frame_reader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : tb_uart_frame_reader
// Brief   : Self-checking bench with a UART FIFO model, an output monitor and
//           a stream-level frame parser used as the reference.
// Revision: 1.0 - initial release
// ============================================================================
module tb_uart_frame_reader;

  localparam logic [7:0] SYNC    = 8'h7E;
  localparam int         MAX_LEN = 16;
  localparam int         RD_GAP  = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       rx_data_present = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       read_from_uart;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_last;
  logic       out_ready = 1'b1;
  logic       frame_error;
  logic [7:0] frame_count;
  logic       busy;

  int n_checks = 0;
  int n_errors = 0;

  uart_frame_reader #(.SYNC(SYNC), .MAX_LEN(MAX_LEN), .RD_GAP(RD_GAP)) dut (
    .clock(clock), .reset(reset),
    .rx_data_present(rx_data_present), .rx_data(rx_data),
    .read_from_uart(read_from_uart),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
    .out_ready(out_ready), .frame_error(frame_error),
    .frame_count(frame_count), .busy(busy)
  );

  always #5 clock = ~clock;

  // UART receive FIFO model: bytes appended to stim, popped on read pulses.
  logic [7:0] stim[$];
  int         rd_ptr = 0;
  always @(negedge clock) begin
    if (read_from_uart && (rd_ptr < stim.size())) rd_ptr = rd_ptr + 1;
    rx_data_present = (rd_ptr < stim.size());
    rx_data         = rx_data_present ? stim[rd_ptr] : 8'h00;
  end

  // Output monitor: logs handshakes, read pulses, error pulses, valid rises.
  int         cyc = 0;
  logic [7:0] got_data[$];
  bit         got_last[$];
  int         read_cyc[$];
  int         err_cyc[$];
  int         vrise_cyc[$];
  int         wide_reads = 0;
  int         drain_reads = 0;
  logic       prev_read = 1'b0;
  logic       prev_valid = 1'b0;
  always @(negedge clock) begin
    cyc = cyc + 1;
    if (out_valid && out_ready) begin
      got_data.push_back(out_data);
      got_last.push_back(out_last);
    end
    if (read_from_uart) begin
      read_cyc.push_back(cyc);
      if (prev_read) wide_reads = wide_reads + 1;
      if (prev_valid) drain_reads = drain_reads + 1;
    end
    if (frame_error) err_cyc.push_back(cyc);
    if (out_valid && !prev_valid) vrise_cyc.push_back(cyc);
    prev_read  = read_from_uart;
    prev_valid = out_valid;
  end

  // Reference: scan a byte stream and list what a correct reader delivers.
  logic [7:0] seq[$];
  logic [7:0] exp_data[$];
  bit         exp_last[$];
  int         exp_err;
  int         exp_frames;

  task automatic model_parse();
    int i = 0;
    int n = seq.size();
    int L;
    int sum;
    exp_data.delete(); exp_last.delete(); exp_err = 0; exp_frames = 0;
    while (i < n) begin
      if (seq[i] != SYNC) begin i++; continue; end
      if (i + 1 >= n) break;
      L = int'(seq[i+1]);
      if (L == 0 || L > MAX_LEN) begin exp_err++; i += 2; continue; end
      if (i + 2 + L >= n) break;
      sum = 0;
      for (int k = 0; k <= L + 1; k++) sum += int'(seq[i+1+k]);
      if (sum % 256 == 0) begin
        exp_frames++;
        for (int k = 0; k < L; k++) begin
          exp_data.push_back(seq[i+2+k]);
          exp_last.push_back(k == L - 1);
        end
      end else begin
        exp_err++;
      end
      i += L + 3;
    end
  endtask

  task automatic load(input logic [127:0] v, input int n);
    seq.delete();
    for (int k = 0; k < n; k++) seq.push_back(v[8*(n-1-k) +: 8]);
  endtask

  task automatic feed();
    for (int k = 0; k < seq.size(); k++) stim.push_back(seq[k]);
  endtask

  task automatic add_frame(input int L, input bit good);
    logic [7:0] b;
    int sum = L;
    seq.push_back(SYNC);
    seq.push_back(8'(L));
    for (int k = 0; k < L; k++) begin
      b = 8'($urandom);
      if ($urandom_range(0, 5) == 0) b = SYNC;
      seq.push_back(b);
      sum += int'(b);
    end
    b = 8'(256 - (sum % 256));
    if (!good) b = b + 8'($urandom_range(1, 255));
    seq.push_back(b);
  endtask

  task automatic do_reset();
    out_ready = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b1;
  endtask

  task automatic wait_idle(input bit rand_ready, input int budget);
    int t = 0;
    int quiet = 0;
    while (quiet < 2 * RD_GAP + 6 && t < budget) begin
      @(posedge clock); #1;
      if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
      t++;
      if (rd_ptr == stim.size() && !out_valid && !read_from_uart) quiet++;
      else quiet = 0;
    end
    out_ready = 1'b1;
    if (t >= budget) begin
      n_checks++; n_errors++;
      $display("FAIL wait_idle: timeout after %0d cycles, %0d bytes left", t, stim.size() - rd_ptr);
    end
  endtask

  // Compare delivered bytes since base against the reference lists.
  task automatic check_stream(input string name, input int base);
    n_checks++;
    if (got_data.size() - base !== exp_data.size()) begin
      n_errors++;
      $display("FAIL %s count: got %0d bytes, expected %0d", name, got_data.size() - base, exp_data.size());
    end else begin
      for (int k = 0; k < exp_data.size(); k++) begin
        n_checks++;
        if (got_data[base+k] !== exp_data[k] || got_last[base+k] !== exp_last[k]) begin
          n_errors++;
          $display("FAIL %s byte %0d: got %02h last=%0b, expected %02h last=%0b", name, k,
                   got_data[base+k], got_last[base+k], exp_data[k], exp_last[k]);
        end
      end
    end
  endtask

  task automatic test_reset();
    #3 reset = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    n_checks++; if (read_from_uart !== 1'b0) begin n_errors++; $display("FAIL reset read_from_uart: got %b expected 0", read_from_uart); end
    n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL reset out_valid: got %b expected 0", out_valid); end
    n_checks++; if (out_data !== 8'h00) begin n_errors++; $display("FAIL reset out_data: got %02h expected 00", out_data); end
    n_checks++; if (out_last !== 1'b0) begin n_errors++; $display("FAIL reset out_last: got %b expected 0", out_last); end
    n_checks++; if (frame_error !== 1'b0) begin n_errors++; $display("FAIL reset frame_error: got %b expected 0", frame_error); end
    n_checks++; if (frame_count !== 8'h00) begin n_errors++; $display("FAIL reset frame_count: got %0d expected 0", frame_count); end
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL reset busy: got %b expected 0", busy); end
    reset = 1'b1;
  endtask

  task automatic test_good_frame();
    int gb, eb, rb, vb;
    do_reset();
    load(128'h7E0311223397, 6);
    model_parse();
    gb = got_data.size(); eb = err_cyc.size(); rb = read_cyc.size(); vb = vrise_cyc.size();
    feed();
    wait_idle(1'b0, 500);
    check_stream("good_frame", gb);
    n_checks++;
    if (frame_count !== 8'(exp_frames)) begin n_errors++; $display("FAIL good_frame frame_count: got %0d expected %0d", frame_count, exp_frames); end
    n_checks++;
    if (err_cyc.size() - eb !== exp_err) begin n_errors++; $display("FAIL good_frame errors: got %0d expected %0d", err_cyc.size() - eb, exp_err); end
    n_checks++;
    if (vrise_cyc.size() - vb !== 1 || read_cyc.size() - rb !== 6 || vrise_cyc[vb] !== read_cyc[rb+5])
      begin n_errors++; $display("FAIL good_frame latency: out_valid did not rise in the cycle after the checksum take"); end
  endtask

  task automatic test_bad_checksum();
    int gb, eb, rb, vb;
    do_reset();
    load(128'h7E02AA55007E015AA5, 9);
    model_parse();
    gb = got_data.size(); eb = err_cyc.size(); rb = read_cyc.size(); vb = vrise_cyc.size();
    feed();
    wait_idle(1'b0, 500);
    check_stream("bad_checksum", gb);
    n_checks++;
    if (err_cyc.size() - eb !== exp_err) begin n_errors++; $display("FAIL bad_checksum errors: got %0d expected %0d", err_cyc.size() - eb, exp_err); end
    else if (read_cyc.size() - rb >= 5) begin
      n_checks++;
      if (err_cyc[eb] !== read_cyc[rb+4]) begin n_errors++; $display("FAIL bad_checksum timing: error cycle %0d, expected %0d", err_cyc[eb], read_cyc[rb+4]); end
    end
    n_checks++;
    if (vrise_cyc.size() - vb !== exp_frames) begin n_errors++; $display("FAIL bad_checksum valid bursts: got %0d expected %0d", vrise_cyc.size() - vb, exp_frames); end
    n_checks++;
    if (frame_count !== 8'(exp_frames)) begin n_errors++; $display("FAIL bad_checksum frame_count: got %0d expected %0d", frame_count, exp_frames); end
  endtask

  task automatic test_resync();
    int gb, eb, rb;
    do_reset();
    load(128'h00417E007E117E015AA5, 10);
    model_parse();
    gb = got_data.size(); eb = err_cyc.size(); rb = read_cyc.size();
    feed();
    wait_idle(1'b0, 500);
    check_stream("resync", gb);
    n_checks++;
    if (err_cyc.size() - eb !== exp_err) begin n_errors++; $display("FAIL resync errors: got %0d expected %0d", err_cyc.size() - eb, exp_err); end
    else if (read_cyc.size() - rb >= 6) begin
      n_checks++;
      if (err_cyc[eb] !== read_cyc[rb+3] || err_cyc[eb+1] !== read_cyc[rb+5])
        begin n_errors++; $display("FAIL resync timing: errors at %0d,%0d expected %0d,%0d", err_cyc[eb], err_cyc[eb+1], read_cyc[rb+3], read_cyc[rb+5]); end
    end
    n_checks++;
    if (frame_count !== 8'(exp_frames)) begin n_errors++; $display("FAIL resync frame_count: got %0d expected %0d", frame_count, exp_frames); end
  endtask

  task automatic test_pacing();
    int rb, wb, db;
    do_reset();
    load(128'h7E03010203F77E015AA5, 10);
    model_parse();
    rb = read_cyc.size(); wb = wide_reads; db = drain_reads;
    feed();
    wait_idle(1'b0, 500);
    n_checks++;
    if (read_cyc.size() - rb !== 10) begin n_errors++; $display("FAIL pacing reads: got %0d expected 10", read_cyc.size() - rb); end
    else begin
      for (int k = 1; k < 6; k++) begin
        n_checks++;
        if (read_cyc[rb+k] - read_cyc[rb+k-1] !== RD_GAP + 1)
          begin n_errors++; $display("FAIL pacing spacing %0d: got %0d cycles expected %0d", k, read_cyc[rb+k] - read_cyc[rb+k-1], RD_GAP + 1); end
      end
    end
    n_checks++;
    if (wide_reads - wb !== 0) begin n_errors++; $display("FAIL pacing width: %0d multi-cycle read pulses", wide_reads - wb); end
    n_checks++;
    if (drain_reads - db !== 0) begin n_errors++; $display("FAIL pacing drain reads: got %0d expected 0", drain_reads - db); end
  endtask

  task automatic test_backpressure();
    int gb, rb2, db, t;
    bit stable;
    do_reset();
    load(128'h7E03112233977E015AA5, 10);
    model_parse();
    gb = got_data.size(); db = drain_reads;
    feed();
    t = 0;
    do begin @(posedge clock); #1; t++; end while (!(out_valid && out_data == 8'h22) && t < 500);
    n_checks++;
    if (t >= 500) begin n_errors++; $display("FAIL backpressure: byte 22 never presented"); end
    out_ready = 1'b0;
    rb2 = read_cyc.size();
    stable = 1'b1;
    repeat (7) begin
      @(posedge clock); #1;
      if (out_valid !== 1'b1 || out_data !== 8'h22 || out_last !== 1'b0) stable = 1'b0;
    end
    n_checks++;
    if (!stable) begin n_errors++; $display("FAIL backpressure hold: got valid=%b data=%02h expected valid=1 data=22", out_valid, out_data); end
    n_checks++;
    if (read_cyc.size() !== rb2) begin n_errors++; $display("FAIL backpressure reads: got %0d reads while held, expected 0", read_cyc.size() - rb2); end
    out_ready = 1'b1;
    wait_idle(1'b0, 500);
    check_stream("backpressure", gb);
    n_checks++;
    if (frame_count !== 8'(exp_frames)) begin n_errors++; $display("FAIL backpressure frame_count: got %0d expected %0d", frame_count, exp_frames); end
    n_checks++;
    if (drain_reads - db !== 0) begin n_errors++; $display("FAIL backpressure drain reads: got %0d expected 0", drain_reads - db); end
  endtask

  task automatic test_reset_mid();
    int gb, eb, rb, t;
    do_reset();
    load(128'h7E040102, 4);
    rb = read_cyc.size(); eb = err_cyc.size();
    feed();
    t = 0;
    while (read_cyc.size() - rb < 4 && t < 500) begin @(posedge clock); #1; t++; end
    @(posedge clock); #1;
    n_checks++;
    if (busy !== 1'b1) begin n_errors++; $display("FAIL reset_mid precondition busy: got %b expected 1", busy); end
    #2 reset = 1'b0;
    #1;
    n_checks++;
    if (busy !== 1'b0 || read_from_uart !== 1'b0 || out_valid !== 1'b0 || out_data !== 8'h00 ||
        out_last !== 1'b0 || frame_error !== 1'b0 || frame_count !== 8'h00)
      begin n_errors++; $display("FAIL reset_mid async clear: busy=%b valid=%b count=%0d expected all zero", busy, out_valid, frame_count); end
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    load(128'h037E015AA5, 5);
    model_parse();
    gb = got_data.size();
    feed();
    wait_idle(1'b0, 500);
    check_stream("reset_mid", gb);
    n_checks++;
    if (err_cyc.size() - eb !== exp_err) begin n_errors++; $display("FAIL reset_mid errors: got %0d expected %0d", err_cyc.size() - eb, exp_err); end
    n_checks++;
    if (frame_count !== 8'(exp_frames)) begin n_errors++; $display("FAIL reset_mid frame_count: got %0d expected %0d", frame_count, exp_frames); end
  endtask

  task automatic test_random();
    int gb, eb, db, wb, kind;
    logic [7:0] b;
    do_reset();
    seq.delete();
    for (int f = 0; f < 30; f++) begin
      kind = $urandom_range(0, 9);
      if (kind <= 5) add_frame($urandom_range(1, MAX_LEN), 1'b1);
      else if (kind == 6) add_frame($urandom_range(1, MAX_LEN), 1'b0);
      else if (kind == 7) begin
        seq.push_back(SYNC);
        seq.push_back(($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(MAX_LEN + 1, 255)));
      end else if (kind == 8) begin
        do b = 8'($urandom); while (b == SYNC);
        seq.push_back(b);
      end else add_frame(MAX_LEN, 1'b1);
    end
    model_parse();
    gb = got_data.size(); eb = err_cyc.size(); db = drain_reads; wb = wide_reads;
    feed();
    wait_idle(1'b1, 20000);
    check_stream("random", gb);
    n_checks++;
    if (err_cyc.size() - eb !== exp_err) begin n_errors++; $display("FAIL random errors: got %0d expected %0d", err_cyc.size() - eb, exp_err); end
    n_checks++;
    if (frame_count !== 8'(exp_frames)) begin n_errors++; $display("FAIL random frame_count: got %0d expected %0d", frame_count, exp_frames); end
    n_checks++;
    if (drain_reads - db !== 0 || wide_reads - wb !== 0)
      begin n_errors++; $display("FAIL random pacing: drain reads %0d, wide pulses %0d, expected 0 and 0", drain_reads - db, wide_reads - wb); end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_bad_checksum();
    test_resync();
    test_pacing();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
